uart_rx_fsm: RTL

- Control-and-sequencing block for the UART receive path.
- Detects the start bit, counts oversampled edges and bits, and recovers each bit by sampling at mid-bit.
- Shifts data into a register and drives the enable and sample inputs of the existing parity checker, `par_chk`.
- Flags stop-bit errors, and raises data_valid only when a frame is received with no errors.

---
 rtl/uart_rx_pkg.sv | 27 ++
 rtl/uart_rx_fsm_if.sv | 26 ++
 rtl/uart_rx_edge_bit_cnt.sv | 44 ++++
 rtl/uart_rx_fsm.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive FSM: state encoding, default sizing
// and small helpers for counter widths and sample voting.
package uart_rx_pkg;

   localparam int PRESCALE_DEF   = 8;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int EDGE_CNT_W     = $clog2(PRESCALE_DEF);
   localparam int BIT_CNT_W      = $clog2(DATA_WIDTH_DEF);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      DONE   = 3'd5
   } state_t;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic majority3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Receive-path signal bundle: serial line and parity-checker handshake in,
// recovered data and frame status out.
interface uart_rx_fsm_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  rx_in;
   logic                  par_en;
   logic                  par_err_in;
   logic                  par_chk_en;
   logic                  sampled_bit;
   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_valid;
   logic                  par_err;
   logic                  stp_err;
   logic                  busy;

   modport master (
      output rx_in, par_en, par_err_in,
      input  par_chk_en, sampled_bit, p_data, data_valid, par_err, stp_err, busy
   );

   modport slave (
      input  rx_in, par_en, par_err_in,
      output par_chk_en, sampled_bit, p_data, data_valid, par_err, stp_err, busy
   );
endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and data-bit counter for the UART receiver,
// with last-edge / last-bit strobes decoded from the registered counts.
module uart_rx_edge_bit_cnt
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE   = PRESCALE_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int EDGE_W     = EDGE_CNT_W,
   parameter int BIT_W      = BIT_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              edge_en,
   input  logic              edge_clr,
   input  logic              bit_en,
   input  logic              bit_clr,
   output logic [EDGE_W-1:0] edge_cnt,
   output logic [BIT_W-1:0]  bit_cnt,
   output logic              last_edge,
   output logic              last_bit
);

   logic [EDGE_W-1:0] edge_cnt_reg;
   logic [BIT_W-1:0]  bit_cnt_reg;

   assign last_edge = (edge_cnt_reg == EDGE_W'(PRESCALE - 1));
   assign last_bit  = (bit_cnt_reg == BIT_W'(DATA_WIDTH - 1));
   assign edge_cnt  = edge_cnt_reg;
   assign bit_cnt   = bit_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst || edge_clr)
         edge_cnt_reg <= '0;
      else if (edge_en)
         edge_cnt_reg <= last_edge ? '0 : edge_cnt_reg + EDGE_W'(1);

      // bit_cnt advances only when a whole bit period has elapsed
      if (rst || bit_clr)
         bit_cnt_reg <= '0;
      else if (bit_en && last_edge)
         bit_cnt_reg <= last_bit ? '0 : bit_cnt_reg + BIT_W'(1);
   end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive sequencer: start detection, mid-bit sampling, deserialisation,
// parity-checker handshake and stop-bit check. UART_RX_MAJORITY_EN selects 3-sample voting.
module uart_rx_fsm
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE   = PRESCALE_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic         clk,
   input  logic         rst,
   uart_rx_fsm_if.slave bus
);

   localparam int EDGE_W = cnt_w(PRESCALE);
   localparam int BIT_W  = cnt_w(DATA_WIDTH);
   localparam int HALF   = PRESCALE / 2;

   localparam logic [EDGE_W-1:0] EDGE_PRE_LAST = EDGE_W'(PRESCALE - 2);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [EDGE_W-1:0] EDGE_S0  = EDGE_W'(HALF - 1);
   localparam logic [EDGE_W-1:0] EDGE_S1  = EDGE_W'(HALF);
   localparam logic [EDGE_W-1:0] EDGE_S2  = EDGE_W'(HALF + 1);
   localparam logic [EDGE_W-1:0] EDGE_UPD = EDGE_W'(HALF + 2);
   logic [2:0] samp_reg;
`else
   localparam logic [EDGE_W-1:0] EDGE_S1  = EDGE_W'(HALF);
   localparam logic [EDGE_W-1:0] EDGE_UPD = EDGE_W'(HALF + 1);
   logic       samp_reg;
`endif

   state_t                state_reg;
   logic                  par_en_lat_reg;
   logic                  sampled_bit_reg;
   logic                  par_chk_en_reg;
   logic                  data_valid_reg;
   logic                  par_err_reg;
   logic                  stp_err_reg;
   logic                  busy_reg;
   logic [DATA_WIDTH-1:0] p_data_vec;

   logic [EDGE_W-1:0] edge_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic              last_edge;
   logic              last_bit;
   logic              counting;
   logic              in_data;
   logic              shift_en;

   assign counting = state_reg inside {START, DATA, PARITY, STOP};
   assign in_data  = (state_reg == DATA);
   assign shift_en = in_data && last_edge;

   uart_rx_edge_bit_cnt #(
      .PRESCALE   (PRESCALE),
      .DATA_WIDTH (DATA_WIDTH),
      .EDGE_W     (EDGE_W),
      .BIT_W      (BIT_W)
   ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .edge_en   (counting),
      .edge_clr  (!counting),
      .bit_en    (in_data),
      .bit_clr   (!in_data),
      .edge_cnt  (edge_cnt),
      .bit_cnt   (bit_cnt),
      .last_edge (last_edge),
      .last_bit  (last_bit)
   );

   // One flop per data bit; each loads only when bit_cnt points at it.
   genvar gi;
   generate
      for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_pdata
         logic bit_reg;
         always_ff @(posedge clk) begin
            if (rst)
               bit_reg <= 1'b0;
            else if (shift_en && (bit_cnt == BIT_W'(gi)))
               bit_reg <= sampled_bit_reg;
         end
         assign p_data_vec[gi] = bit_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         par_en_lat_reg  <= 1'b0;
         samp_reg        <= '0;
         sampled_bit_reg <= 1'b0;
         par_chk_en_reg  <= 1'b0;
         data_valid_reg  <= 1'b0;
         par_err_reg     <= 1'b0;
         stp_err_reg     <= 1'b0;
         busy_reg        <= 1'b0;
      end else begin
         par_chk_en_reg <= 1'b0;
         data_valid_reg <= 1'b0;

         if (counting) begin
`ifdef UART_RX_MAJORITY_EN
            if (edge_cnt == EDGE_S0) samp_reg[0] <= bus.rx_in;
            if (edge_cnt == EDGE_S1) samp_reg[1] <= bus.rx_in;
            if (edge_cnt == EDGE_S2) samp_reg[2] <= bus.rx_in;
            if (edge_cnt == EDGE_UPD) sampled_bit_reg <= majority3(samp_reg);
`else
            if (edge_cnt == EDGE_S1) samp_reg <= bus.rx_in;
            if (edge_cnt == EDGE_UPD) sampled_bit_reg <= samp_reg;
`endif
         end

         case (state_reg)
            IDLE: begin
               if (!bus.rx_in) begin
                  state_reg      <= START;
                  par_en_lat_reg <= bus.par_en;
                  par_err_reg    <= 1'b0;
                  stp_err_reg    <= 1'b0;
                  busy_reg       <= 1'b1;
               end
            end
            START: begin
               // a start bit that reads high at mid-bit was only a glitch
               if (last_edge) begin
                  if (sampled_bit_reg) begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                  end else begin
                     state_reg <= DATA;
                  end
               end
            end
            DATA: begin
               if (last_edge && last_bit)
                  state_reg <= par_en_lat_reg ? PARITY : STOP;
            end
            PARITY: begin
               // registered enable lands exactly on the last-edge cycle
               if (edge_cnt == EDGE_PRE_LAST)
                  par_chk_en_reg <= 1'b1;
               if (last_edge) begin
                  par_err_reg <= bus.par_err_in;
                  state_reg   <= STOP;
               end
            end
            STOP: begin
               if (last_edge) begin
                  stp_err_reg    <= ~sampled_bit_reg;
                  data_valid_reg <= ~(par_err_reg | ~sampled_bit_reg);
                  state_reg      <= DONE;
               end
            end
            DONE: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.par_chk_en  = par_chk_en_reg;
   assign bus.sampled_bit = sampled_bit_reg;
   assign bus.p_data      = p_data_vec;
   assign bus.data_valid  = data_valid_reg;
   assign bus.par_err     = par_err_reg;
   assign bus.stp_err     = stp_err_reg;
   assign bus.busy        = busy_reg;

endmodule
